page_map_cmd: RTL and testbench

- Initiator side of the page-map update interface: queues page ADD/DEL requests from the host register block and issues them one at a time on the op/from/size bus to the page-map responder.
- Waits for the responder's valid handshake before issuing the next request.
- Range-checks every request so the responder never sees a zero-length or out-of-range page span.
- Sits between the host-side register decoder and page_map, in the clk200 domain.

---
 rtl/page_map_cmd_if.sv | 30 +++
 rtl/page_map_cmd.sv | 167 ++++++++++++++++
 tb/tb_page_map_cmd.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/page_map_cmd_if.sv
// page_map_cmd_if
//   Host request handshake plus the op/from/size bus toward page_map.
//   slave  : the command initiator (page_map_cmd) - takes requests, drives the bus.
//   master : its environment - host register decoder and page_map responder.
// Signals:
//   req_valid/req_ready    request handshake, transfer when both high
//   req_op/req_from/req_size  request payload (op 0=NONE 1=ADD 2=DEL 3=reserved)
//   op/from/size           command bus to page_map
//   map_valid              page_map handshake back to the initiator
interface page_map_cmd_if;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [7:0] req_from;
   logic [7:0] req_size;
   logic [1:0] op;
   logic [7:0] from;
   logic [7:0] size;
   logic       map_valid;

   modport master (
      output req_valid, req_op, req_from, req_size, map_valid,
      input  req_ready, op, from, size
   );

   modport slave (
      input  req_valid, req_op, req_from, req_size, map_valid,
      output req_ready, op, from, size
   );
endinterface

// File: rtl/page_map_cmd.sv
// page_map_cmd
//   Queues page ADD/DEL requests from the host and issues them one at a time
//   to page_map, waiting for map_valid to drop and rise again between
//   commands. Requests are range-checked on entry: zero-length or reserved
//   requests are dropped, spans running past page 255 are clipped.
// Ports:
//   clk200       200 MHz clock
//   a8_rst_n     synchronous active-low reset
//   bus          page_map_cmd_if.slave (request handshake, op/from/size, map_valid)
//   busy         queue non-empty or command in flight
//   pending      queued entries, excluding the in-flight one
//   err_clip     1-cycle pulse: accepted request span was clipped
//   err_drop     1-cycle pulse: request discarded (size 0 or op NONE/reserved)
//   err_timeout  1-cycle pulse: a handshake phase exceeded TIMEOUT cycles
module page_map_cmd #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                     clk200,
   input  logic                     a8_rst_n,
   page_map_cmd_if.slave            bus,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   pending,
   output logic                     err_clip,
   output logic                     err_drop,
   output logic                     err_timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   localparam logic [1:0] OP_NONE = 2'd0;
   localparam logic [1:0] OP_ADD  = 2'd1;
   localparam logic [1:0] OP_DEL  = 2'd2;

   typedef struct packed {
      logic [1:0] op;
      logic [7:0] from;
      logic [7:0] size;
   } req_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;

   req_t [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count, count_nxt;
   logic             rdy_q;

   state_t           state;
   logic [TW-1:0]    wcnt;
   logic [1:0]       op_q;
   logic [7:0]       from_q, size_q;

   logic             push_req, req_ok, push, pop, clip;
   logic [8:0]       span_end;
   logic [7:0]       size_in;
   req_t             head;

   // ---------------- accept stage ----------------
   assign push_req = bus.req_valid & rdy_q;
   assign req_ok   = ((bus.req_op == OP_ADD) || (bus.req_op == OP_DEL)) &&
                     (bus.req_size != 8'd0);
   assign push     = push_req & req_ok;

   // 9-bit end of span; anything past page 255 is trimmed to end at 256.
   // Clipping implies from >= 1, so 256-from always fits in 8 bits.
   assign span_end = {1'b0, bus.req_from} + {1'b0, bus.req_size};
   assign clip     = span_end > 9'd256;
   assign size_in  = clip ? 8'(9'd256 - {1'b0, bus.req_from}) : bus.req_size;

   // ---------------- queue ----------------
   assign pop       = (state == IDLE) && (count != '0);
   assign head      = mem[rd_ptr];
   assign count_nxt = count + CW'(push) - CW'(pop);

   always_ff @(posedge clk200) begin
      if (!a8_rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rdy_q    <= 1'b0;
         err_clip <= 1'b0;
         err_drop <= 1'b0;
      end else begin
         err_clip <= push & clip;
         err_drop <= push_req & ~req_ok;
         if (push) begin
            mem[wr_ptr] <= '{op: bus.req_op, from: bus.req_from, size: size_in};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         // Ready is registered from the next fill level so it is never
         // stale and stays low while in reset.
         rdy_q <= (count_nxt != FULL);
      end
   end

   // ---------------- issue FSM ----------------
   always_ff @(posedge clk200) begin
      if (!a8_rst_n) begin
         state       <= IDLE;
         wcnt        <= '0;
         op_q        <= OP_NONE;
         from_q      <= 8'd0;
         size_q      <= 8'd0;
         err_timeout <= 1'b0;
      end else begin
         err_timeout <= 1'b0;
         op_q        <= OP_NONE;   // op is a single-cycle strobe
         case (state)
            IDLE: begin
               if (pop) begin
                  op_q   <= head.op;
                  from_q <= head.from;
                  size_q <= head.size;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT_LOW;
               wcnt  <= '0;
            end
            WAIT_LOW: begin
               if (!bus.map_valid) begin
                  state <= WAIT_HIGH;
                  wcnt  <= '0;
               end else if (wcnt == TO_LAST) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
                  wcnt        <= '0;
               end else begin
                  wcnt <= wcnt + TW'(1);
               end
            end
            WAIT_HIGH: begin
               if (bus.map_valid) begin
                  state <= IDLE;
                  wcnt  <= '0;
               end else if (wcnt == TO_LAST) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
                  wcnt        <= '0;
               end else begin
                  wcnt <= wcnt + TW'(1);
               end
            end
            default: begin
               state <= IDLE;
               wcnt  <= '0;
            end
         endcase
      end
   end

   assign bus.req_ready = rdy_q;
   assign bus.op        = op_q;
   assign bus.from      = from_q;
   assign bus.size      = size_q;
   assign pending       = count;
   assign busy          = (state != IDLE) | (count != '0);

endmodule

// File: tb/tb_page_map_cmd.sv
// tb_page_map_cmd
//   Drives page_map_cmd through directed scenarios and a randomized phase.
//   A queue-based reference model tracks what the outputs must be on every
//   cycle; literal checks in the directed scenarios pin the model.
module tb_page_map_cmd;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 1023;

   logic       clk200 = 1'b0;
   logic       a8_rst_n = 1'b0;
   logic       busy;
   logic [2:0] pending;
   logic       err_clip, err_drop, err_timeout;

   always #5 clk200 = ~clk200;

   page_map_cmd_if bus_if ();

   page_map_cmd #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk200      (clk200),
      .a8_rst_n    (a8_rst_n),
      .bus         (bus_if),
      .busy        (busy),
      .pending     (pending),
      .err_clip    (err_clip),
      .err_drop    (err_drop),
      .err_timeout (err_timeout)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int op_cnt = 0;
   int last_op_cyc = 0;

   always @(posedge clk200) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int op;
      int from;
      int size;
   } ent_t;

   ent_t mq[$];
   int   m_phase;     // 0 idle, 1 issuing, 2 waiting valid low, 3 waiting valid high
   int   m_wait;
   int   e_op, e_from, e_size;
   bit   e_ready, e_clip, e_drop, e_to;
   bit   model_on = 1'b0;
   bit   m_pop;
   ent_t m_h, m_n;

   always @(posedge clk200) begin
      if (!a8_rst_n) begin
         mq.delete();
         m_phase = 0; m_wait = 0;
         e_op = 0; e_from = 0; e_size = 0;
         e_ready = 0; e_clip = 0; e_drop = 0; e_to = 0;
         model_on = 1'b1;
      end else begin
         e_op = 0; e_clip = 0; e_drop = 0; e_to = 0;
         m_pop = (m_phase == 0) && (mq.size() > 0);
         if (m_phase == 1) begin
            m_phase = 2; m_wait = 0;
         end else if (m_phase == 2 || m_phase == 3) begin
            // phase 2 waits for valid low, phase 3 for valid high
            if (bus_if.map_valid == (m_phase == 3)) begin
               m_phase = (m_phase == 2) ? 3 : 0;
               m_wait = 0;
            end else begin
               m_wait++;
               if (m_wait == TIMEOUT) begin
                  e_to = 1; m_phase = 0; m_wait = 0;
               end
            end
         end
         if (m_pop) begin
            m_h = mq.pop_front();
            e_op = m_h.op; e_from = m_h.from; e_size = m_h.size;
            m_phase = 1;
         end
         if (bus_if.req_valid && e_ready) begin
            if ((bus_if.req_op == 2'd1 || bus_if.req_op == 2'd2) && bus_if.req_size != 8'd0) begin
               m_n.op   = int'(bus_if.req_op);
               m_n.from = int'(bus_if.req_from);
               m_n.size = int'(bus_if.req_size);
               if (m_n.from + m_n.size > 256) begin
                  m_n.size = 256 - m_n.from;
                  e_clip = 1;
               end
               mq.push_back(m_n);
            end else begin
               e_drop = 1;
            end
         end
         e_ready = (mq.size() != DEPTH);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk200) begin
      if (model_on) begin
         check("op",          32'(bus_if.op),        32'(e_op));
         check("from",        32'(bus_if.from),      32'(e_from));
         check("size",        32'(bus_if.size),      32'(e_size));
         check("req_ready",   32'(bus_if.req_ready), 32'(e_ready));
         check("busy",        32'(busy),             32'((m_phase != 0) || (mq.size() != 0)));
         check("pending",     32'(pending),          32'(mq.size()));
         check("err_clip",    32'(err_clip),         32'(e_clip));
         check("err_drop",    32'(err_drop),         32'(e_drop));
         check("err_timeout", 32'(err_timeout),      32'(e_to));
      end
      if (bus_if.op !== 2'd0) begin
         op_cnt++;
         last_op_cyc = cyc;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk200);
      #1;
   endtask

   // Present one request and hold it until the handshake completes.
   task automatic send(input int op, input int from, input int size);
      logic rdy;
      int   n;
      bus_if.req_valid = 1'b1;
      bus_if.req_op    = 2'(op);
      bus_if.req_from  = 8'(from);
      bus_if.req_size  = 8'(size);
      n = 0;
      do begin
         rdy = bus_if.req_ready;
         tick();
         n++;
      end while (!rdy && n < 3000);
      check("send_accepted", 32'(rdy), 32'd1);
      bus_if.req_valid = 1'b0;
   endtask

   // Random responder until the block goes idle.
   task automatic drain();
      int n;
      n = 0;
      while ((busy || n < 2) && n < 3000) begin
         bus_if.map_valid = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      check("drain_idle", 32'(busy), 32'd0);
      bus_if.map_valid = 1'b1;
      tick();
   endtask

   int c0, n, t_op;

   initial begin
      bus_if.req_valid = 1'b0;
      bus_if.req_op    = 2'd0;
      bus_if.req_from  = 8'd0;
      bus_if.req_size  = 8'd0;
      bus_if.map_valid = 1'b1;

      // reset values
      a8_rst_n = 1'b0;
      tick(); tick();
      check("rst_ready", 32'(bus_if.req_ready), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_op",    32'(bus_if.op), 32'd0);
      a8_rst_n = 1'b1;
      tick();
      check("ready_after_release", 32'(bus_if.req_ready), 32'd1);

      // single ADD with a slow responder
      send(1, 8'h10, 8'h04);
      tick();
      check("t1_op",   32'(bus_if.op),   32'd1);
      check("t1_from", 32'(bus_if.from), 32'h10);
      check("t1_size", 32'(bus_if.size), 32'h04);
      tick();
      check("t1_op_cleared", 32'(bus_if.op), 32'd0);
      bus_if.map_valid = 1'b0;
      repeat (3) tick();
      check("t1_busy_wait", 32'(busy), 32'd1);
      bus_if.map_valid = 1'b1;
      tick();
      check("t1_busy_done", 32'(busy), 32'd0);
      tick();

      // span clip
      send(2, 8'hFC, 8'h10);
      check("clip_pulse", 32'(err_clip), 32'd1);
      tick();
      check("clip_op",   32'(bus_if.op),   32'd2);
      check("clip_from", 32'(bus_if.from), 32'hFC);
      check("clip_size", 32'(bus_if.size), 32'h04);
      tick();
      bus_if.map_valid = 1'b0;
      tick(); tick();
      bus_if.map_valid = 1'b1;
      tick(); tick();

      // drops
      c0 = op_cnt;
      send(1, 8'h20, 8'h00);
      check("drop_size0", 32'(err_drop), 32'd1);
      send(3, 8'h20, 8'h05);
      check("drop_rsvd",  32'(err_drop), 32'd1);
      check("drop_pending", 32'(pending), 32'd0);
      repeat (4) tick();
      check("drop_no_op", 32'(op_cnt), 32'(c0));

      // fill with a stalled responder, then WAIT_LOW timeout
      bus_if.map_valid = 1'b1;
      for (int i = 0; i <= DEPTH; i++) send(1 + (i % 2), i * 16, 3);
      check("fill_ready", 32'(bus_if.req_ready), 32'd0);
      check("fill_pending", 32'(pending), 32'(DEPTH));
      t_op = last_op_cyc;
      n = 0;
      while (!err_timeout && n < 1100) begin
         tick();
         n++;
      end
      check("timeout_seen", 32'(err_timeout), 32'd1);
      check("timeout_latency", 32'(cyc - t_op), 32'(TIMEOUT + 1));
      drain();

      // enqueue and dequeue on the same edge
      send(1, 8'h01, 8'h01);
      tick();
      bus_if.map_valid = 1'b0;
      send(2, 8'h02, 8'h02);
      tick();
      bus_if.map_valid = 1'b1;
      tick();
      check("simul_pre_pending", 32'(pending), 32'd1);
      send(1, 8'h03, 8'h03);
      check("simul_pending", 32'(pending), 32'd1);
      check("simul_op",   32'(bus_if.op),   32'd2);
      check("simul_from", 32'(bus_if.from), 32'h02);
      drain();

      // reset while waiting for valid high with two entries queued
      send(1, 8'h40, 8'h01);
      tick();
      bus_if.map_valid = 1'b0;
      send(2, 8'h50, 8'h02);
      send(1, 8'h60, 8'h03);
      check("rstw_pending", 32'(pending), 32'd2);
      check("rstw_busy",    32'(busy), 32'd1);
      a8_rst_n = 1'b0;
      tick();
      check("rstw_op",      32'(bus_if.op),   32'd0);
      check("rstw_from",    32'(bus_if.from), 32'd0);
      check("rstw_size",    32'(bus_if.size), 32'd0);
      check("rstw_busy0",   32'(busy), 32'd0);
      check("rstw_pending0", 32'(pending), 32'd0);
      check("rstw_ready",   32'(bus_if.req_ready), 32'd0);
      a8_rst_n = 1'b1;
      bus_if.map_valid = 1'b1;
      c0 = op_cnt;
      repeat (20) tick();
      check("rstw_no_op", 32'(op_cnt), 32'(c0));

      // randomized traffic and responder
      for (int i = 0; i < 3000; i++) begin
         bus_if.req_valid = 1'($urandom_range(0, 1));
         bus_if.req_op    = 2'($urandom_range(0, 3));
         bus_if.req_from  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255))
                                                         : 8'($urandom_range(0, 255));
         bus_if.req_size  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         if ($urandom_range(0, 2) == 0) bus_if.map_valid = ~bus_if.map_valid;
         tick();
      end
      bus_if.req_valid = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
